// File: rtl/block_emitter_pkg.sv
// Shared types and constants for the block emitter.
// Op codes, FSM states, word lengths and ASCII values.
package block_emitter_pkg;

  typedef enum logic [1:0] {
    OP_BEGIN  = 2'b00,
    OP_END    = 2'b01,
    OP_FILLER = 2'b10,
    OP_SPACE  = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic [2:0] LEN_BEGIN  = 3'd6;
  localparam logic [2:0] LEN_END    = 3'd4;
  localparam logic [2:0] LEN_FILLER = 3'd2;
  localparam logic [2:0] LEN_SPACE  = 3'd1;

  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] CASE_OFS = 8'h20;
  localparam logic [7:0] CH_LO_A  = 8'h61;
  localparam logic [7:0] CH_LO_Z  = 8'h7A;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_D     = 8'h64;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_X     = 8'h78;

  localparam logic [7:0] DEPTH_MAX = 8'hFF;
  localparam logic [7:0] DEPTH_MIN = 8'h00;

  function automatic logic [2:0] word_len(input op_e op);
    logic [2:0] len;
    len = LEN_SPACE;
    case (op)
      OP_BEGIN:  len = LEN_BEGIN;
      OP_END:    len = LEN_END;
      OP_FILLER: len = LEN_FILLER;
      OP_SPACE:  len = LEN_SPACE;
      default:   len = LEN_SPACE;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] apply_case(
    input logic [7:0] ch,
    input logic       upper
  );
    logic [7:0] res;
    res = ch;
    if (upper && ch >= CH_LO_A && ch <= CH_LO_Z)
      res = ch - CASE_OFS;
    return res;
  endfunction

endpackage

// File: rtl/block_emitter_char_rom.sv
// Character table: maps (op, index, upper) to one ASCII character.
// 'last' flags the trailing space of each word.
module block_char_rom
  import block_emitter_pkg::*;
(
  input  op_e        op_i,
  input  logic [2:0] idx_i,
  input  logic       upper_i,
  output logic [7:0] char_o,
  output logic       last_o
);

  logic [7:0] lc;
  logic [2:0] len;

  // Lower-case lookup, then case folding and end-of-word detection
  always_comb begin
    lc  = CH_NUL;
    len = word_len(op_i);
    case (op_i)
      OP_BEGIN: begin
        case (idx_i)
          3'd0:    lc = CH_B;
          3'd1:    lc = CH_E;
          3'd2:    lc = CH_G;
          3'd3:    lc = CH_I;
          3'd4:    lc = CH_N;
          3'd5:    lc = SPACE;
          default: lc = CH_NUL;
        endcase
      end
      OP_END: begin
        case (idx_i)
          3'd0:    lc = CH_E;
          3'd1:    lc = CH_N;
          3'd2:    lc = CH_D;
          3'd3:    lc = SPACE;
          default: lc = CH_NUL;
        endcase
      end
      OP_FILLER: begin
        case (idx_i)
          3'd0:    lc = CH_X;
          3'd1:    lc = SPACE;
          default: lc = CH_NUL;
        endcase
      end
      OP_SPACE: begin
        case (idx_i)
          3'd0:    lc = SPACE;
          default: lc = CH_NUL;
        endcase
      end
      default: lc = CH_NUL;
    endcase
    char_o = apply_case(lc, upper_i);
    last_o = (idx_i == len - 3'd1);
  end

endmodule

// File: rtl/block_emitter.sv
// Block emitter: turns BEGIN/END/FILLER/SPACE commands into text.
// Tracks nesting depth with sticky underflow/overflow flags.
module block_emitter
  import block_emitter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic       cmd_upper,
  output logic       cmd_ready,
  output logic       out_valid,
  output logic [7:0] out_char,
  input  logic       out_ready,
  output logic [7:0] depth,
  output logic       balanced,
  output logic       underflow,
  output logic       overflow
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic       upper_q, upper_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] depth_q, depth_d;
  logic       under_q, under_d;
  logic       over_q, over_d;

  logic [7:0] rom_char;
  logic       rom_last;
  logic       accept;
  logic       out_hs;

  block_char_rom u_rom (
    .op_i    (op_q),
    .idx_i   (idx_q),
    .upper_i (upper_q),
    .char_o  (rom_char),
    .last_o  (rom_last)
  );

  assign accept = cmd_valid && (state_q == IDLE);
  assign out_hs = (state_q == EMIT) && out_ready;

  // State register and latched command fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_BEGIN;
      upper_q <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      upper_q <= upper_d;
      idx_q   <= idx_d;
    end
  end

  // Next state, char index and handshake outputs
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    upper_d   = upper_q;
    idx_d     = idx_q;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    out_char  = CH_NUL;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          upper_d = cmd_upper;
          idx_d   = 3'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_char  = rom_char;
        if (out_hs) begin
          if (rom_last) begin
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Depth and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= DEPTH_MIN;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      depth_q <= depth_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  // Saturating depth update at command acceptance
  always_comb begin
    depth_d = depth_q;
    under_d = under_q;
    over_d  = over_q;
    if (accept) begin
      case (op_e'(cmd_op))
        OP_BEGIN: begin
          if (depth_q == DEPTH_MAX) over_d = 1'b1;
          else depth_d = depth_q + 8'd1;
        end
        OP_END: begin
          if (depth_q == DEPTH_MIN) under_d = 1'b1;
          else depth_d = depth_q - 8'd1;
        end
        default: depth_d = depth_q;
      endcase
    end
  end

  assign depth     = depth_q;
  assign underflow = under_q;
  assign overflow  = over_q;
  assign balanced  = (depth_q == DEPTH_MIN) && !under_q && !over_q;

endmodule

// File: tb/tb_block_emitter.sv
// Directed bench for block_emitter with a queue-based text model.
// Per-cycle compare plus literal checks of the emitted strings.
module tb_block_emitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_upper;
  logic       cmd_ready;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready;
  logic [7:0] depth;
  logic       balanced;
  logic       underflow;
  logic       overflow;

  int passed = 0;
  int total  = 0;

  logic [7:0] mq[$];
  logic [7:0] log_q[$];
  int         m_depth;
  bit         m_under;
  bit         m_over;

  block_emitter dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_upper (cmd_upper),
    .cmd_ready (cmd_ready),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_ready (out_ready),
    .depth     (depth),
    .balanced  (balanced),
    .underflow (underflow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  function automatic string word_of(input logic [1:0] op);
    case (op)
      2'b00:   return "begin ";
      2'b01:   return "end ";
      2'b10:   return "x ";
      default: return " ";
    endcase
  endfunction

  // Model: a word is a queue of characters; ready means queue empty
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_depth = 0;
      m_under = 0;
      m_over  = 0;
    end else if (mq.size() != 0) begin
      if (out_ready) void'(mq.pop_front());
    end else if (cmd_valid) begin
      string w;
      logic [7:0] c;
      w = word_of(cmd_op);
      for (int i = 0; i < w.len(); i++) begin
        c = w[i];
        if (cmd_upper && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
        mq.push_back(c);
      end
      if (cmd_op == 2'b00) begin
        if (m_depth == 255) m_over = 1;
        else m_depth++;
      end else if (cmd_op == 2'b01) begin
        if (m_depth == 0) m_under = 1;
        else m_depth--;
      end
    end
  end

  // Record every character the sink actually takes
  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) log_q.push_back(out_char);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst out_char", {24'd0, out_char}, 32'd0);
      chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst balanced", {31'd0, balanced}, 32'd1);
      chk("rst depth", {24'd0, depth}, 32'd0);
    end else begin
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, mq.size() == 0});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0)
        chk("out_char", {24'd0, out_char}, {24'd0, mq[0]});
      chk("depth", {24'd0, depth}, m_depth);
      chk("underflow", {31'd0, underflow}, {31'd0, m_under});
      chk("overflow", {31'd0, overflow}, {31'd0, m_over});
      chk("balanced", {31'd0, balanced},
          {31'd0, (m_depth == 0) && !m_under && !m_over});
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    log_q.delete();
  endtask

  // Present one command; returns #1 after the accepting edge
  task automatic send(input logic [1:0] op, input logic up);
    cmd_op    = op;
    cmd_upper = up;
    cmd_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (cmd_ready) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("send timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 50; n++) begin
      if (cmd_ready) return;
      @(posedge clk);
      #1;
    end
    chk("drain timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_log(input string name, input string exp);
    logic [7:0] e;
    chk($sformatf("%s len", name), log_q.size(), exp.len());
    for (int i = 0; i < exp.len() && i < log_q.size(); i++) begin
      e = exp[i];
      chk($sformatf("%s[%0d]", name, i), {24'd0, log_q[i]}, {24'd0, e});
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_upper = 1'b0;
    out_ready = 1'b1;
    do_reset();

    // Single word, lower case
    send(2'b00, 1'b0);
    drain();
    chk_log("single", "begin ");
    chk("single b", {24'd0, log_q[0]}, 32'h62);
    chk("single n", {24'd0, log_q[4]}, 32'h6E);
    chk("single depth", {24'd0, depth}, 32'd1);
    chk("single bal", {31'd0, balanced}, 32'd0);

    // Balanced pair, upper case
    do_reset();
    send(2'b00, 1'b1);
    send(2'b01, 1'b1);
    drain();
    chk_log("pair", "BEGIN END ");
    chk("pair B", {24'd0, log_q[0]}, 32'h42);
    chk("pair depth", {24'd0, depth}, 32'd0);
    chk("pair bal", {31'd0, balanced}, 32'd1);

    // Backpressure in the middle of "end "
    do_reset();
    out_ready = 1'b0;
    send(2'b01, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp hold", {24'd0, out_char}, 32'h6E);
      chk("bp ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    chk_log("bp", "end ");

    // Underflow and its stickiness
    do_reset();
    send(2'b01, 1'b0);
    chk("uf flag", {31'd0, underflow}, 32'd1);
    drain();
    chk_log("uf", "end ");
    chk("uf depth", {24'd0, depth}, 32'd0);
    chk("uf bal", {31'd0, balanced}, 32'd0);
    send(2'b00, 1'b0);
    send(2'b01, 1'b0);
    drain();
    chk("uf bal after", {31'd0, balanced}, 32'd0);
    chk("uf depth after", {24'd0, depth}, 32'd0);

    // Overflow at the 256th BEGIN
    do_reset();
    for (int i = 0; i < 255; i++) send(2'b10 - 2'b10, 1'b0);
    chk("of 255 depth", {24'd0, depth}, 32'd255);
    chk("of 255 flag", {31'd0, overflow}, 32'd0);
    send(2'b00, 1'b0);
    chk("of 256 depth", {24'd0, depth}, 32'd255);
    chk("of 256 flag", {31'd0, overflow}, 32'd1);
    drain();

    // Reset in the middle of "begin "
    do_reset();
    send(2'b00, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid 3rd", {24'd0, out_char}, 32'h67);
    reset = 1'b1;
    #1;
    chk("mid valid", {31'd0, out_valid}, 32'd0);
    chk("mid depth", {24'd0, depth}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    log_q.delete();
    send(2'b11, 1'b0);
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk_log("mid", " ");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1);
  end

endmodule

// File: doc/block_emitter.md
BLOCK_EMITTER -- requirements
Module: block_emitter

Interface
REQ-001 The module SHALL have these ports, one per line (name  direction  width  meaning):
  clk  input  1  clock; all state changes on the rising edge.
  reset  input  1  reset, asynchronous, active-high.
  cmd_valid  input  1  command request.
  cmd_op  input  2  command: 00 BEGIN, 01 END, 10 FILLER, 11 SPACE.
  cmd_upper  input  1  1 = emit letters in upper case.
  cmd_ready  output  1  the command is accepted when cmd_valid and cmd_ready are both high.
  out_valid  output  1  out_char is valid.
  out_char  output  8  ASCII character.
  out_ready  input  1  the sink accepts the character when out_valid and out_ready are both high.
  depth  output  8  current BEGIN nesting depth.
  balanced  output  1  stream emitted so far is block-balanced.
  underflow  output  1  sticky; an END was issued at depth 0.
  overflow  output  1  sticky; a BEGIN was issued at depth 255.

Function
REQ-002 The block SHALL serialise accepted commands into a character stream of words separated by spaces, one character per out handshake.
REQ-003 Each command SHALL produce the following character sequence:
  BEGIN: "begin " (6 characters).
  END: "end " (4 characters).
  FILLER: "x " (2 characters).
  SPACE: " " (1 character).
REQ-004 When cmd_upper=1, letters SHALL be emitted in upper case ("BEGIN ", "END ", "X "); space (0x20) is never affected by case.
REQ-005 The FSM SHALL have two states, IDLE and EMIT; cmd_ready SHALL equal (state==IDLE).
REQ-006 In IDLE, a command handshake SHALL latch op and upper, clear the 3-bit char index to 0, and enter EMIT; the first character SHALL appear on out_valid in the next cycle.
REQ-007 In EMIT, out_valid SHALL be 1 and out_char SHALL be the character selected by (latched op, index, latched upper).
REQ-008 On an out handshake the index SHALL increment; on the handshake of the final character (the space) the FSM SHALL return to IDLE. There is one idle bubble between words.
REQ-009 While out_valid=1 and out_ready=0, out_char SHALL remain stable.
REQ-010 Commands presented while cmd_ready=0 SHALL be ignored, with no side effects.
REQ-011 depth, underflow and overflow SHALL update in the cycle the command is accepted, not at emission time:
  BEGIN: depth+1; at 255, depth holds and overflow is set.
  END: depth-1; at 0, depth holds and underflow is set.
  FILLER and SPACE: no change.
REQ-012 balanced SHALL be combinational: (depth==0) && !underflow && !overflow.
REQ-013 underflow and overflow SHALL stay set until reset; a failed stream is never recovered, the same as the checker side.
REQ-014 The emitted characters SHALL still be produced for an underflowing END or an overflowing BEGIN; only the counters saturate.
REQ-015 out_ready held high in IDLE SHALL have no effect.

Reset
REQ-016 Reset SHALL force state=IDLE, index=0, depth=0, underflow=0 and overflow=0.
REQ-017 During reset the outputs SHALL be: out_valid=0, out_char=0x00, cmd_ready=1, balanced=1.
REQ-018 A reset asserted mid-word SHALL abort the word immediately; no remaining characters are emitted after release.
REQ-019 The first command after reset release SHALL be accepted on the first rising edge at which cmd_valid=1.

Structure
REQ-020 A shared package block_emitter_pkg SHALL hold:
  the op codes (OP_BEGIN, OP_END, OP_FILLER, OP_SPACE);
  the state encoding (IDLE, EMIT);
  the word lengths (6, 4, 2, 1);
  the ASCII constants, including SPACE=8'h20 and the case offset 8'h20.
REQ-021 A combinational sub-module block_char_rom SHALL map (op, index, upper) to (char, last). The FSM and counters SHALL stay in block_emitter.
REQ-022 Depth arithmetic SHALL be 8-bit unsigned with explicit saturation checks; there SHALL be no wrap-around.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
  Single word: BEGIN, upper=0, out_ready=1 -> out_char 0x62,0x65,0x67,0x69,0x6E,0x20 on 6 consecutive cycles starting 1 cycle after acceptance; depth=1; balanced=0.
  Balanced pair: BEGIN then END, upper=1 -> "BEGIN END "; depth returns to 0; balanced=1.
  Backpressure: out_ready=0 for 3 cycles mid-"end " -> out_char holds 0x6E; no character is lost or duplicated; cmd_ready=0 throughout.
  Underflow: END at depth 0 -> "end " is still emitted; depth=0; underflow=1; balanced=0; a following BEGIN then END still leaves balanced=0.
  Overflow: 256 BEGINs -> depth=255; overflow=1 on the 256th.
  Reset mid-word: reset during the 3rd character of "begin " -> out_valid=0 immediately; depth=0; after release a SPACE command yields exactly one 0x20.
